// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Owns the single write port of the register file. After reset, or on request,
// it sweeps zeroes into registers 1..NUM_REGS-1 (CLEAR). Otherwise (RUN) it
// shares the port between the CPU writeback path (fixed priority) and a
// debug/loader port. A starvation counter forces a debug grant after
// STARVE_LIMIT consecutive denied debug cycles. The outputs drive the
// register file pins directly, so an accepted write lands on the same edge.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   clear_req         one-cycle request to start a clear sweep (ignored in CLEAR)
//   cpu_we/addr/data  CPU write request; cpu_ready = accepted this cycle
//   dbg_valid/addr/data debug write request; dbg_ready = accepted this cycle
//   rf_we, rf_write_addr, rf_write_data  register file write port
//   busy              high while sweeping (and during reset)
//   clear_done        registered one-cycle pulse after a sweep finishes
module regfile_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int NUM_REGS     = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_ready,
    input  logic              dbg_valid,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              busy,
    output logic              clear_done
);

    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(NUM_REGS - 1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [SCNT_W-1:0] SCNT_ZERO = {SCNT_W{1'b0}};
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
    localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              clear_done_q, clear_done_d;

    // State register: all control state, reset to the start of a sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= PTR_FIRST;
            scnt_q       <= SCNT_ZERO;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            scnt_q       <= scnt_d;
            clear_done_q <= clear_done_d;
        end
    end

    // Next-state logic: sweep pointer advance, starvation tracking, clear entry.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        scnt_d       = scnt_q;
        clear_done_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                // scnt holds across a sweep; clear_req is not a restart here
                if (ptr_q == PTR_LAST) begin
                    state_d      = ST_RUN;
                    ptr_d        = PTR_FIRST;
                    clear_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + PTR_FIRST;
                end
            end
            ST_RUN: begin
                // Count only denied debug cycles; any accept or idle debug resets
                if (dbg_valid && !dbg_ready) begin
                    if (scnt_q != SCNT_MAX) begin
                        scnt_d = scnt_q + SCNT_ONE;
                    end else begin
                        scnt_d = scnt_q;
                    end
                end else begin
                    scnt_d = SCNT_ZERO;
                end
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = PTR_FIRST;
                    scnt_d  = SCNT_ZERO;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = PTR_FIRST;
                scnt_d  = SCNT_ZERO;
            end
        endcase
    end

    // Output logic: reset override, sweep writes, and RUN arbitration.
    always_comb begin
        rf_we         = 1'b0;
        rf_write_addr = ADDR_ZERO;
        rf_write_data = DATA_ZERO;
        cpu_ready     = 1'b0;
        dbg_ready     = 1'b0;
        busy          = 1'b1;
        if (rst) begin
            // Port is held quiet while reset is asserted
            busy = 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    rf_we         = 1'b1;
                    rf_write_addr = ptr_q;
                    busy          = 1'b1;
                end
                ST_RUN: begin
                    busy = 1'b0;
                    if (dbg_valid && (scnt_q == SCNT_MAX)) begin
                        // Starved debug overrides the CPU for one cycle
                        dbg_ready     = 1'b1;
                        rf_we         = (dbg_addr != ADDR_ZERO);
                        rf_write_addr = dbg_addr;
                        rf_write_data = dbg_data;
                    end else if (cpu_we) begin
                        cpu_ready     = 1'b1;
                        rf_we         = (cpu_addr != ADDR_ZERO);
                        rf_write_addr = cpu_addr;
                        rf_write_data = cpu_data;
                    end else if (dbg_valid) begin
                        dbg_ready     = 1'b1;
                        rf_we         = (dbg_addr != ADDR_ZERO);
                        rf_write_addr = dbg_addr;
                        rf_write_data = dbg_data;
                    end else begin
                        // Nobody requesting: advertise ready to both sides
                        cpu_ready = 1'b1;
                        dbg_ready = 1'b1;
                    end
                end
                default: begin
                    busy = 1'b1;
                end
            endcase
        end
    end

    assign clear_done = clear_done_q;

endmodule
